// File: rtl/mdu_pkg.sv
// mdu_pkg: MDU opcodes, default multiply/divide latencies and counter sizing
package mdu_pkg;
   localparam logic [3:0] MDU_NONE  = 4'd0;
   localparam logic [3:0] MDU_MULT  = 4'd1;
   localparam logic [3:0] MDU_MULTU = 4'd2;
   localparam logic [3:0] MDU_DIV   = 4'd3;
   localparam logic [3:0] MDU_DIVU  = 4'd4;
   localparam logic [3:0] MDU_MFHI  = 4'd5;
   localparam logic [3:0] MDU_MFLO  = 4'd6;
   localparam logic [3:0] MDU_MTHI  = 4'd7;
   localparam logic [3:0] MDU_MTLO  = 4'd8;
   localparam int MDU_MULT_CYCLES = 5;
   localparam int MDU_DIV_CYCLES  = 10;
   function automatic int cnt_width(input int n);
      return ($clog2(n + 1) > 4) ? $clog2(n + 1) : 4;
   endfunction
endpackage

// File: rtl/mdu.sv
// mdu: EX-stage multiply/divide unit with HI/LO registers and multi-cycle busy window
//   clk, reset (sync, active-low), A/B forwarded operands, MDUOp opcode, en valid,
//   start (accepted this cycle), busy (op in flight), HI/LO registers, MDUOut (mfhi/mflo result)
module mdu
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MDU_MULT_CYCLES,
   parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [3:0]  MDUOp,
   input  logic        en,
   output logic        start,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDUOut
);
   localparam int CW = cnt_width(MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES);
   logic [31:0] hi_q, hi_d, lo_q, lo_d, phi_q, phi_d, plo_q, plo_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic busy_q, busy_d;
   logic is_mul, is_div, sgn, na, nb;
   logic [31:0] ma, mb, bd, uq, ur;
   logic [63:0] prod;
   assign is_mul = MDUOp == MDU_MULT || MDUOp == MDU_MULTU;
   assign is_div = MDUOp == MDU_DIV || MDUOp == MDU_DIVU;
   assign sgn    = MDUOp == MDU_MULT || MDUOp == MDU_DIV;
   assign na     = sgn & A[31];
   assign nb     = sgn & B[31];
   // sign-extended operands: low 64 bits of the product are right for both signednesses
   assign prod   = {{32{na}}, A} * {{32{nb}}, B};
   // signed divide done on magnitudes so 0x80000000 / -1 never overflows
   assign ma     = na ? -A : A;
   assign mb     = nb ? -B : B;
   assign bd     = (mb == 32'd0) ? 32'd1 : mb;
   assign uq     = ma / bd;
   assign ur     = ma % bd;
   assign start  = en & (is_mul | is_div) & ~busy_q;
   assign busy   = busy_q;
   assign HI     = hi_q;
   assign LO     = lo_q;
   assign MDUOut = (MDUOp == MDU_MFHI) ? hi_q : (MDUOp == MDU_MFLO) ? lo_q : 32'd0;
   always_comb begin
      hi_d   = hi_q;
      lo_d   = lo_q;
      phi_d  = phi_q;
      plo_d  = plo_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (start) begin
         // divide by zero latches the current HI/LO so completion leaves them unchanged
         phi_d  = is_mul ? prod[63:32] : (mb == 32'd0) ? hi_q : (na ? -ur : ur);
         plo_d  = is_mul ? prod[31:0] : (mb == 32'd0) ? lo_q : (na ^ nb ? -uq : uq);
         cnt_d  = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
         busy_d = 1'b1;
      end else if (busy_q) begin
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            hi_d   = phi_q;
            lo_d   = plo_q;
            busy_d = 1'b0;
         end
      end else if (en) begin
         hi_d = (MDUOp == MDU_MTHI) ? A : hi_q;
         lo_d = (MDUOp == MDU_MTLO) ? A : lo_q;
      end
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         hi_q   <= '0;
         lo_q   <= '0;
         phi_q  <= '0;
         plo_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         phi_q  <= phi_d;
         plo_q  <= plo_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed plus randomized checks of mdu against a behavioural HI/LO model
module tb_mdu;
   import mdu_pkg::*;
   logic clk = 1'b0, reset = 1'b0, en = 1'b0;
   logic start, busy;
   logic [31:0] a_i = '0, b_i = '0, hi, lo, mdu_out;
   logic [3:0] op = MDU_NONE;
   logic [31:0] m_hi = '0, m_lo = '0;
   int total = 0, bad = 0;
   mdu dut (
      .clk(clk), .reset(reset), .A(a_i), .B(b_i), .MDUOp(op), .en(en),
      .start(start), .busy(busy), .HI(hi), .LO(lo), .MDUOut(mdu_out)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      longint p, sx, sy;
      longint unsigned u;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (o == MDU_MULT) begin
         p = sx * sy;
         m_hi = p[63:32];
         m_lo = p[31:0];
      end else if (o == MDU_MULTU) begin
         u = {32'd0, x} * {32'd0, y};
         m_hi = u[63:32];
         m_lo = u[31:0];
      end else if (o == MDU_DIV && y != 0) begin
         p = sx / sy;
         m_lo = p[31:0];
         p = sx % sy;
         m_hi = p[31:0];
      end else if (o == MDU_DIVU && y != 0) begin
         m_lo = x / y;
         m_hi = x % y;
      end
   endtask
   task automatic do_md(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic [3:0] intr);
      int n, cyc;
      logic [31:0] old_lo;
      n = (o == MDU_MULT || o == MDU_MULTU) ? 5 : 10;
      old_lo = m_lo;
      op = o; a_i = x; b_i = y; en = 1'b1; #1;
      chk("start_idle", {31'd0, start}, 32'd1);
      model(o, x, y);
      @(posedge clk); #1;
      op = MDU_MFLO; a_i = $urandom; b_i = $urandom; #1;
      cyc = 0;
      while (busy === 1'b1 && cyc < 40) begin
         if (cyc == 2 && intr != MDU_NONE) begin
            op = intr; #1;
            chk("start_while_busy", {31'd0, start}, 32'd0);
         end else begin
            chk("mflo_during_busy", mdu_out, old_lo);
         end
         cyc++;
         @(posedge clk); #1;
         op = MDU_MFLO; #1;
      end
      chk("busy_cycles", cyc, n);
      chk("hi_result", hi, m_hi);
      chk("lo_result", lo, m_lo);
   endtask
   task automatic do_mt(input logic [3:0] o, input logic [31:0] x);
      op = o; a_i = x; en = 1'b1; #1;
      chk("mt_no_start", {31'd0, start}, 32'd0);
      @(posedge clk); #1;
      if (o == MDU_MTHI) m_hi = x; else m_lo = x;
      op = (o == MDU_MTHI) ? MDU_MFHI : MDU_MFLO; a_i = $urandom; #1;
      chk("mf_after_mt", mdu_out, x);
      chk("mt_hi", hi, m_hi);
      chk("mt_lo", lo, m_lo);
   endtask
   initial begin
      logic [3:0] ops [6];
      logic [3:0] o;
      logic [31:0] x, y;
      ops = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO};
      op = MDU_MULT; @(posedge clk); #1;
      chk("start_en0", {31'd0, start}, 32'd0);
      en = 1'b1; #1;
      chk("start_in_reset", {31'd0, start}, 32'd1);
      @(posedge clk); #1;
      chk("busy_after_reset_start", {31'd0, busy}, 32'd0);
      chk("hi_reset", hi, 32'd0);
      chk("lo_reset", lo, 32'd0);
      reset = 1'b1; en = 1'b0; op = MDU_NONE; #1;
      chk("mduout_none", mdu_out, 32'd0);
      do_md(MDU_MULT, 32'hFFFFFFFF, 32'h2, MDU_MULT);
      chk("mult_hi_const", hi, 32'hFFFFFFFF);
      chk("mult_lo_const", lo, 32'hFFFFFFFE);
      do_md(MDU_MULTU, 32'hFFFFFFFF, 32'h2, MDU_NONE);
      chk("multu_hi_const", hi, 32'h1);
      do_md(MDU_DIV, 32'hFFFFFFF9, 32'h2, MDU_NONE);
      chk("div_lo_const", lo, 32'hFFFFFFFD);
      chk("div_hi_const", hi, 32'hFFFFFFFF);
      do_mt(MDU_MTHI, 32'h11);
      do_mt(MDU_MTLO, 32'h22);
      do_md(MDU_DIVU, 32'h7, 32'h0, MDU_MTHI);
      chk("divz_hi_const", hi, 32'h11);
      chk("divz_lo_const", lo, 32'h22);
      do_md(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, MDU_MTLO);
      chk("div_ovf_lo", lo, 32'h80000000);
      chk("div_ovf_hi", hi, 32'h0);
      do_mt(MDU_MTHI, 32'h12345678);
      op = MDU_MTLO; a_i = 32'hDEADBEEF; en = 1'b0;
      @(posedge clk); #1;
      chk("mtlo_en0", lo, m_lo);
      for (int i = 0; i < 30; i++) begin
         o = ops[$urandom_range(0, 5)];
         x = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
         y = ($urandom_range(0, 5) == 0) ? 32'h0 : ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFF : $urandom;
         if (o == MDU_MTHI || o == MDU_MTLO) do_mt(o, x);
         else do_md(o, x, y, ($urandom_range(0, 1) == 1) ? MDU_MTLO : MDU_NONE);
      end
      op = MDU_DIV; a_i = 32'd100; b_i = 32'd7; en = 1'b1;
      @(posedge clk); #1;
      op = MDU_NONE; en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("busy_before_reset", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      m_hi = '0; m_lo = '0;
      chk("busy_mid_reset", {31'd0, busy}, 32'd0);
      chk("hi_mid_reset", hi, 32'd0);
      chk("lo_mid_reset", lo, 32'd0);
      repeat (12) @(posedge clk);
      #1;
      chk("hi_stays_reset", hi, 32'd0);
      do_md(MDU_MULTU, 32'd3, 32'd4, MDU_NONE);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit in the EX stage, fed the same forwarded operands `A`/`B` as the ALU. It executes `mult`, `multu`, `div`, `divu`, `mthi`, `mtlo`, `mfhi` and `mflo` against internal HI/LO registers. Multiply and divide take multiple cycles. The unit exposes `start`/`busy` so the hazard controller can stall later HI/LO-dependent instructions in D. `MDUOut` is the EX-stage result for `mfhi`/`mflo`, muxed with the ALU output `C` ahead of the E/M register.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`.

Ports:
- `clk` input, 1: clock; all state updates on rising edge.
- `reset` input, 1: synchronous, active-low; sampled on rising edge of `clk`.
- `A` input, 32: rs operand, forwarded.
- `B` input, 32: rt operand, forwarded.
- `MDUOp` input, 4: operation code, one of the `MDU_*` constants.
- `en` input, 1: EX instruction valid (not bubble/flushed); qualifies `MDUOp`.
- `start` output, 1: combinational; high when `en`, `MDUOp` ∈ {MULT, MULTU, DIV, DIVU} and `busy`=0.
- `busy` output, 1: registered; high while an operation is in flight.
- `HI` output, 32: current HI register.
- `LO` output, 32: current LO register.
- `MDUOut` output, 32: combinational; HI for MFHI, LO for MFLO, otherwise 0.

## Operation
- State:
  - HI, LO (32 each).
  - Pending result pHI, pLO (32 each).
  - Down-counter `cnt`, 4 bits minimum, sized for `DIV_CYCLES`.
  - `busy`.
- IDLE (`busy`=0): on an edge with `start`=1:
  - Compute the result from `A`/`B` into pHI/pLO (behavioural `*` and `/`/`%` are allowed).
  - Load `cnt` with `MULT_CYCLES` or `DIV_CYCLES`.
  - Set `busy`=1.
- BUSY: each edge decrements `cnt`. On the edge where `cnt`==1: HI<=pHI, LO<=pLO, `cnt`<=0, `busy`<=0.
- Arithmetic:
  - MULT: signed 32×32→64. HI=upper 32 bits, LO=lower 32 bits.
  - MULTU: same as MULT, unsigned.
  - DIV: signed. LO=quotient, truncated toward zero. HI=remainder, with the dividend's sign. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (B==0, DIV or DIVU): still busy for `DIV_CYCLES`; HI/LO are left unchanged at completion.
- MTHI/MTLO:
  - With `en`=1 and `busy`=0, HI (or LO) <= A at the edge.
  - Ignored while `busy`=1.
- MFHI/MFLO: pure reads of the registered HI/LO. While `busy`=1 the pre-operation value is returned.
- Ops while busy:
  - MULT/MULTU/DIV/DIVU/MTHI/MTLO with `en`=1 while `busy`=1 are ignored; `start` stays 0.
  - The controller must prevent this: stall in D while `start|busy` and the D instruction is an MDU op.
  - The bench flags it as a protocol violation.
- MDU_NONE, or `en`=0: no state change.

## Timing
- Reset (`reset`=0 at an edge): HI=LO=0, pHI=pLO=0, `cnt`=0, `busy`=0, regardless of any operation in flight. It overrides a simultaneous `start`. Combinational outputs follow: `start` is 0 only if `en`=0; `MDUOut` is 0 for non-MF ops.
- Start accepted at edge E0:
  - `busy`=1 from E0 through the N-th following edge. N=`MULT_CYCLES` or `DIV_CYCLES`.
  - `busy`=0 and new HI/LO visible after edge E0+N.
  - Exactly N cycles of `busy`=1.
- `start` and `busy` are never both 1.
- Back-to-back: a new `start` may be accepted in the first cycle where `busy`=0, i.e. at edge E0+N+1.
- MTHI/MTLO: one-edge latency; an MFHI/MFLO in the following cycle sees the new value.
- `MDUOut`: zero cycles from `MDUOp` to output; it reflects HI/LO as of the current cycle.

## Structure
- The `MDU_*` opcodes go in the shared `head.v` define header alongside the `ALU_*` codes:
  - MDU_NONE=0, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MFHI, MDU_MFLO, MDU_MTHI, MDU_MTLO.
- The default cycle counts are also defines in `head.v` and feed the parameters.
- Single module `mdu`; no sub-module is natural. Counter and result latch are inline.

## Test plan
- MULT A=0xFFFFFFFF, B=0x00000002:
  - `busy` high exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - MFLO during busy returns the old LO.
- MULTU with the same operands: HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (−7), B=2: `busy` for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=7, B=0, with HI=0x11, LO=0x22 beforehand:
  - `busy` 10 cycles.
  - HI/LO remain 0x11/0x22.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI A=0x12345678, then MFHI next cycle: `MDUOut`=0x12345678.
- MULT issued during `busy`: `start`=0 and the result is unchanged.
- `reset` driven low at the 4th busy cycle of a DIV: after that edge `busy`=0 and HI=LO=0.
